adc_uart_sequencer: RTL and testbench

Periodic controller that sequences the SAR ADC and the UART transmitter. On every sample tick it requests one conversion, waits for the 8-bit result, formats it as two upper-case ASCII hex characters plus CR LF, and pushes the four bytes through the UART start/done handshake. It replaces ad-hoc character stepping at the top level. It also reports dropped ticks and conversion timeouts.

---
 rtl/adc_uart_sequencer_if.sv | 28 ++
 rtl/adc_uart_sequencer.sv | 168 ++++++++++++++++
 tb/tb_adc_uart_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_uart_sequencer_if.sv
// Handshake bundle between the sample sequencer, the SAR ADC and the UART transmitter.
// The sequencer side is the master; the ADC/UART side is the slave.
interface adc_uart_sequencer_if;
    logic       adc_start;
    logic       adc_valid;
    logic [7:0] adc_data;
    logic [7:0] uart_data;
    logic       uart_start;
    logic       uart_done;

    modport master (
        output adc_start,
        input  adc_valid,
        input  adc_data,
        output uart_data,
        output uart_start,
        input  uart_done
    );

    modport slave (
        input  adc_start,
        output adc_valid,
        output adc_data,
        input  uart_data,
        input  uart_start,
        output uart_done
    );
endinterface

// File: rtl/adc_uart_sequencer.sv
// Periodic sampler: one ADC conversion per tick, sent over the UART as two hex chars plus CR LF.
// Counts ticks dropped while a frame is in flight and conversions that timed out.
module adc_uart_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 5000000,
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      enable,
    adc_uart_sequencer_if.master      bus,
    output logic                      busy,
    output logic [CNT_W-1:0]          skip_count,
    output logic [CNT_W-1:0]          timeout_count
);

    localparam int unsigned TickW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StLoad,
        StSend,
        StWaitDone
    } state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       sample_q, sample_d;
    logic             tmo_mode_q, tmo_mode_d;
    logic [1:0]       idx_q, idx_d;
    logic             seen_idle_q, seen_idle_d;
    logic             adc_start_q, adc_start_d;
    logic [7:0]       uart_data_q, uart_data_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic [CNT_W-1:0] tmo_count_q, tmo_count_d;
    logic             tick;

    function automatic logic [7:0] hex_char(logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_char(logic [1:0] i, logic [7:0] s, logic m);
        logic [7:0] c;
        case (i)
            2'd0:    c = m ? 8'h2D : hex_char(s[7:4]);
            2'd1:    c = m ? 8'h2D : hex_char(s[3:0]);
            2'd2:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    assign tick = enable && (tick_cnt_q == TickW'(SAMPLE_PERIOD - 1));
    assign busy = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        sample_d    = sample_q;
        tmo_mode_d  = tmo_mode_q;
        idx_d       = idx_q;
        seen_idle_d = seen_idle_q;
        adc_start_d = 1'b0;
        uart_data_d = uart_data_q;
        skip_d      = skip_q;
        tmo_count_d = tmo_count_q;

        if (enable) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
        end

        if (tick && busy && (skip_q != '1)) begin
            skip_d = skip_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d     = StConvert;
                    adc_start_d = 1'b1;
                    tmo_cnt_d   = '0;
                end
            end
            StConvert: begin
                // A result arriving on the expiry cycle still wins over the timeout.
                if (bus.adc_valid) begin
                    sample_d   = bus.adc_data;
                    tmo_mode_d = 1'b0;
                    state_d    = StLoad;
                end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
                    tmo_mode_d = 1'b1;
                    state_d    = StLoad;
                    if (tmo_count_q != '1) begin
                        tmo_count_d = tmo_count_q + CNT_W'(1);
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StLoad: begin
                idx_d       = 2'd0;
                seen_idle_d = 1'b0;
                uart_data_d = frame_char(2'd0, sample_q, tmo_mode_q);
                state_d     = StSend;
            end
            StSend: begin
                // Require an idle->busy transition so a stale busy level is not taken as acceptance.
                if (bus.uart_done) begin
                    seen_idle_d = 1'b1;
                end else if (seen_idle_q) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (bus.uart_done) begin
                    if (idx_q == 2'd3) begin
                        state_d = StIdle;
                    end else begin
                        idx_d       = idx_q + 2'd1;
                        seen_idle_d = 1'b0;
                        uart_data_d = frame_char(idx_q + 2'd1, sample_q, tmo_mode_q);
                        state_d     = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            sample_q    <= 8'h00;
            tmo_mode_q  <= 1'b0;
            idx_q       <= 2'd0;
            seen_idle_q <= 1'b0;
            adc_start_q <= 1'b0;
            uart_data_q <= 8'h00;
            skip_q      <= '0;
            tmo_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            sample_q    <= sample_d;
            tmo_mode_q  <= tmo_mode_d;
            idx_q       <= idx_d;
            seen_idle_q <= seen_idle_d;
            adc_start_q <= adc_start_d;
            uart_data_q <= uart_data_d;
            skip_q      <= skip_d;
            tmo_count_q <= tmo_count_d;
        end
    end

    assign bus.adc_start  = adc_start_q;
    assign bus.uart_start = (state_q == StSend);
    assign bus.uart_data  = uart_data_q;
    assign skip_count     = skip_q;
    assign timeout_count  = tmo_count_q;

endmodule

// File: tb/tb_adc_uart_sequencer.sv
// Scoreboard bench for adc_uart_sequencer: ADC and UART behavioural models, expected bytes
// queued by the directed sequence and checked by an independent monitor.
module tb_adc_uart_sequencer;

    localparam int unsigned P = 64;
    localparam int unsigned T = 16;
    localparam int unsigned W = 2;

    logic         CLOCK_50 = 1'b0;
    logic         reset;
    logic         enable;
    logic         busy;
    logic [W-1:0] skip_count;
    logic [W-1:0] timeout_count;

    adc_uart_sequencer_if bus();

    adc_uart_sequencer #(
        .SAMPLE_PERIOD (P),
        .TIMEOUT       (T),
        .CNT_W         (W)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .enable        (enable),
        .bus           (bus),
        .busy          (busy),
        .skip_count    (skip_count),
        .timeout_count (timeout_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         adc_starts = 0;
    logic [7:0] exp_q[$];

    bit         adc_respond = 1'b1;
    int         adc_delay = 10;
    logic [7:0] adc_value = 8'h00;
    int         uart_lat = 3;
    int         uart_hold = 4;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait expired at cycle %0d", name, cyc);
    endtask

    task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1);
        exp_q.push_back(c0);
        exp_q.push_back(c1);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_adc_start(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge CLOCK_50);
            if (bus.adc_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("wait_adc_start");
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge CLOCK_50);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("wait_idle");
    endtask

    // ADC model: answers adc_start after adc_delay cycles; data bus holds junk otherwise.
    initial begin
        bus.adc_valid = 1'b0;
        bus.adc_data  = 8'hEE;
        forever begin
            @(negedge CLOCK_50);
            if (bus.adc_start && adc_respond) begin
                repeat (adc_delay) @(negedge CLOCK_50);
                bus.adc_valid = 1'b1;
                bus.adc_data  = adc_value;
                @(negedge CLOCK_50);
                bus.adc_valid = 1'b0;
                bus.adc_data  = 8'hEE;
            end
        end
    end

    // UART model: goes busy uart_lat cycles after a start request, for uart_hold cycles.
    initial begin
        bus.uart_done = 1'b1;
        forever begin
            @(negedge CLOCK_50);
            if (bus.uart_start && bus.uart_done) begin
                repeat (uart_lat) @(negedge CLOCK_50);
                bus.uart_done = 1'b0;
                repeat (uart_hold) @(negedge CLOCK_50);
                bus.uart_done = 1'b1;
            end
        end
    end

    // Monitor: pops one expected byte per uart_start rise; checks pulse width and data hold.
    initial begin
        logic       prev_start;
        logic       prev_adc;
        logic [7:0] held;
        prev_start = 1'b0;
        prev_adc   = 1'b0;
        held       = 8'h00;
        forever begin
            @(negedge CLOCK_50);
            if (bus.adc_start) begin
                adc_starts++;
                check("adc_start_one_cycle", {31'd0, prev_adc}, 32'd0);
            end
            if (bus.uart_start && !prev_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL uart_byte: unexpected byte %0h at cycle %0d", bus.uart_data, cyc);
                end else begin
                    check("uart_byte", {24'd0, bus.uart_data}, {24'd0, exp_q.pop_front()});
                end
                held = bus.uart_data;
            end else if (bus.uart_start) begin
                check("uart_data_stable", {24'd0, bus.uart_data}, {24'd0, held});
            end
            prev_start = bus.uart_start;
            prev_adc   = bus.adc_start;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_en;
        int t0;
        int t1;
        int base;
        bit ok;
        logic [1:0] tmo_exp [3];
        logic prev;

        tmo_exp[0] = 2'd2;
        tmo_exp[1] = 2'd3;
        tmo_exp[2] = 2'd3;

        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_adc_start", {31'd0, bus.adc_start}, 32'd0);
        check("rst_uart_start", {31'd0, bus.uart_start}, 32'd0);
        check("rst_uart_data", {24'd0, bus.uart_data}, 32'h00);
        check("rst_skip", {30'd0, skip_count}, 32'd0);
        check("rst_timeout", {30'd0, timeout_count}, 32'd0);
        reset = 1'b0;

        // Normal conversion, two periods, then enable dropped mid-frame.
        adc_respond = 1'b1;
        adc_delay   = 10;
        adc_value   = 8'hA7;
        push_frame(8'h41, 8'h37);
        push_frame(8'h41, 8'h37);
        base   = adc_starts;
        enable = 1'b1;
        t_en   = cyc;
        wait_adc_start(100);
        t0 = cyc;
        check("first_tick_latency", t0 - t_en, 32'd64);
        repeat (11) @(negedge CLOCK_50);
        check("load_no_start", {31'd0, bus.uart_start}, 32'd0);
        @(negedge CLOCK_50);
        check("valid_to_start_2", {31'd0, bus.uart_start}, 32'd1);
        wait_adc_start(100);
        t1 = cyc;
        check("tick_period", t1 - t0, 32'd64);
        enable = 1'b0;
        wait_idle(300);
        check("t1_adc_starts", adc_starts - base, 32'd2);
        check("t1_skip", {30'd0, skip_count}, 32'd0);
        check("t1_timeout", {30'd0, timeout_count}, 32'd0);

        // ADC never answers: timeout marker frame.
        adc_respond = 1'b0;
        push_frame(8'h2D, 8'h2D);
        enable = 1'b1;
        wait_adc_start(100);
        enable = 1'b0;
        repeat (15) @(negedge CLOCK_50);
        check("t2_timeout_before", {30'd0, timeout_count}, 32'd0);
        @(negedge CLOCK_50);
        check("t2_timeout_after", {30'd0, timeout_count}, 32'd1);
        wait_idle(300);

        // Result arrives on the expiry cycle: data wins.
        adc_respond = 1'b1;
        adc_delay   = 15;
        adc_value   = 8'h05;
        push_frame(8'h30, 8'h35);
        enable = 1'b1;
        wait_adc_start(100);
        enable = 1'b0;
        wait_idle(300);
        check("t6_no_timeout", {30'd0, timeout_count}, 32'd1);

        // Slow UART: ticks during the frame are skipped and saturate at 3.
        adc_delay = 10;
        adc_value = 8'h3C;
        uart_hold = 200;
        push_frame(8'h33, 8'h43);
        base   = adc_starts;
        enable = 1'b1;
        wait_adc_start(100);
        repeat (63) @(negedge CLOCK_50);
        check("t3_skip_c63", {30'd0, skip_count}, 32'd0);
        @(negedge CLOCK_50);
        check("t3_skip_c64", {30'd0, skip_count}, 32'd1);
        repeat (63) @(negedge CLOCK_50);
        check("t3_skip_c127", {30'd0, skip_count}, 32'd1);
        @(negedge CLOCK_50);
        check("t3_skip_c128", {30'd0, skip_count}, 32'd2);
        repeat (64) @(negedge CLOCK_50);
        check("t3_skip_c192", {30'd0, skip_count}, 32'd3);
        repeat (64) @(negedge CLOCK_50);
        check("t3_skip_sat", {30'd0, skip_count}, 32'd3);
        check("t3_still_busy", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        wait_idle(1500);
        check("t3_one_adc_start", adc_starts - base, 32'd1);
        uart_hold = 4;

        // Timeout counter saturation.
        adc_respond = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_frame(8'h2D, 8'h2D);
            enable = 1'b1;
            wait_adc_start(100);
            enable = 1'b0;
            wait_idle(300);
            check("t4_timeout_sat", {30'd0, timeout_count}, {30'd0, tmo_exp[k]});
        end

        // Reset while char1 is being offered.
        adc_respond = 1'b1;
        adc_delay   = 10;
        adc_value   = 8'h5A;
        exp_q.push_back(8'h35);
        exp_q.push_back(8'h41);
        enable = 1'b1;
        wait_adc_start(100);
        enable = 1'b0;
        ok   = 1'b0;
        prev = 1'b0;
        for (int n = 0, i = 0; i < 200; i++) begin
            @(negedge CLOCK_50);
            if (bus.uart_start && !prev) n++;
            prev = bus.uart_start;
            if (n == 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("t5_wait_char1");
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("t5_uart_start", {31'd0, bus.uart_start}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_uart_data", {24'd0, bus.uart_data}, 32'h00);
        check("t5_skip", {30'd0, skip_count}, 32'd0);
        check("t5_timeout", {30'd0, timeout_count}, 32'd0);
        check("t5_bytes_seen", exp_q.size(), 32'd0);
        reset  = 1'b0;
        push_frame(8'h35, 8'h41);
        enable = 1'b1;
        t_en   = cyc;
        wait_adc_start(100);
        check("t5_restart_latency", cyc - t_en, 32'd64);
        enable = 1'b0;
        wait_idle(300);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
